// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time, and hands instructions to decode.
// Optional IFU_MISALIGN_CHECK_EN turns misaligned redirects into a sticky fault state.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] inst_q, inst_nxt;
  logic        stale, stale_nxt;
  logic [31:0] redir_tgt;
  logic        redir_fault;

`ifdef IFU_MISALIGN_CHECK_EN
  assign redir_tgt   = redirect_pc;
  assign redir_fault = |redirect_pc[1:0];
`else
  // Low bits are dropped so the PC always stays word aligned.
  logic unused_lsb;
  assign unused_lsb  = ^redirect_pc[1:0];
  assign redir_tgt   = {redirect_pc[31:2], 2'b00};
  assign redir_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      inst_q <= '0;
      stale  <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      inst_q <= inst_nxt;
      stale  <= stale_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = inst_q;
    stale_nxt = stale;
    if (redirect_valid && state != S_FAULT) begin
      // A redirect wins over every other transition; an in-flight fetch is marked stale.
      pc_nxt = redir_tgt;
      if (redir_fault) begin
        state_nxt = S_FAULT;
        stale_nxt = 1'b0;
      end else begin
        case (state)
          S_REQ: begin
            if (req_ready) begin
              state_nxt = S_WAIT;
              stale_nxt = 1'b1;
            end
          end
          S_WAIT: begin
            if (rsp_valid) begin
              state_nxt = S_REQ;
              stale_nxt = 1'b0;
            end else begin
              stale_nxt = 1'b1;
            end
          end
          default: state_nxt = S_REQ;
        endcase
      end
    end else begin
      case (state)
        S_IDLE: state_nxt = S_REQ;
        S_REQ: begin
          if (req_ready) begin
            state_nxt = S_WAIT;
            stale_nxt = 1'b0;
          end
        end
        S_WAIT: begin
          if (rsp_valid) begin
            if (!stale) begin
              inst_nxt  = rsp_data;
              state_nxt = S_HOLD;
            end else begin
              state_nxt = S_REQ;
            end
            stale_nxt = 1'b0;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            pc_nxt    = pc + 32'd4;
            state_nxt = S_REQ;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_valid  = (state == S_REQ);
  assign inst_valid = (state == S_HOLD);
  assign req_addr   = pc;
  assign inst_pc    = pc;
  assign inst       = inst_q;
`ifdef IFU_MISALIGN_CHECK_EN
  assign fetch_fault = (state == S_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed test-plan scenarios with literal expectations, then randomized
// traffic compared every cycle against a transaction-level model of the fetch unit.
module tb_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  // Model: fetch progress as flags (started, request outstanding, instruction held, faulted).
  logic [31:0] m_pc, m_inst;
  bit m_live, m_out, m_stale, m_hold, m_fault;

  // Memory: one pending response with a countdown.
  int          pend = -1;
  logic [31:0] pend_addr;
  int          mem_dly = 0;
  bit          ovr_en = 0;
  logic [31:0] ovr_data;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (ovr_en) return ovr_data;
    return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1357};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] dv, input logic [31:0] mv,
                     input logic [31:0] exp);
    chk(name, dv, exp);
    chk({name, "_model"}, mv, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h8000_0000; m_inst = '0;
    m_live = 0; m_out = 0; m_stale = 0; m_hold = 0; m_fault = 0;
  endtask

  function automatic bit e_req();
    return m_live && !m_out && !m_hold && !m_fault;
  endfunction

  task automatic model_step();
    bit acc, got, cons, mis;
    logic [31:0] tgt;
    if (m_fault) return;
    acc  = e_req() && req_ready;
    got  = m_out && rsp_valid;
    cons = m_hold && inst_ready;
`ifdef IFU_MISALIGN_CHECK_EN
    tgt = redirect_pc;
    mis = (redirect_pc % 4) != 0;
`else
    tgt = redirect_pc - (redirect_pc % 4);
    mis = 0;
`endif
    if (redirect_valid) begin
      m_pc = tgt;
      if (mis) begin
        m_fault = 1; m_out = 0; m_hold = 0; m_stale = 0;
      end else begin
        m_live = 1; m_hold = 0;
        if (acc) begin m_out = 1; m_stale = 1; end
        else if (got) begin m_out = 0; m_stale = 0; end
        else if (m_out) m_stale = 1;
      end
    end else if (!m_live) m_live = 1;
    else if (acc) begin m_out = 1; m_stale = 0; end
    else if (got) begin
      m_out = 0;
      if (!m_stale) begin m_hold = 1; m_inst = rsp_data; end
      m_stale = 0;
    end else if (cons) begin
      m_hold = 0; m_pc = m_pc + 32'd4;
    end
  endtask

  // One clock: model advances on the edge, memory answers, redirect pulse ends.
  task automatic tick();
    bit acc;
    logic [31:0] a;
    acc = req_valid && req_ready;
    a   = req_addr;
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    redirect_valid = 0;
    rsp_valid = 0;
    if (pend == 0) begin
      rsp_valid = 1; rsp_data = mem_fn(pend_addr); pend = -1;
    end else if (pend > 0) pend--;
    if (acc) begin
      pend_addr = a;
      if (mem_dly == 0) begin rsp_valid = 1; rsp_data = mem_fn(a); end
      else pend = mem_dly - 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    tick();
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_valid", 32'(req_valid), 32'(e_req()));
      chk("inst_valid", 32'(inst_valid), 32'(m_hold));
      chk("req_addr", req_addr, m_pc);
      chk("inst_pc", inst_pc, m_pc);
      chk("inst", inst, m_inst);
      chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    end
  end

  initial begin
    rst_n = 0; req_ready = 0; rsp_valid = 0; rsp_data = '0; inst_ready = 0;
    redirect_valid = 0; redirect_pc = '0;
    model_reset();
    tick(); tick();
    cmp_en = 1;
    lit("rst_req_valid", 32'(req_valid), 32'(e_req()), 0);
    lit("rst_inst_valid", 32'(inst_valid), 32'(m_hold), 0);
    lit("rst_req_addr", req_addr, m_pc, 32'h8000_0000);
    lit("rst_inst_pc", inst_pc, m_pc, 32'h8000_0000);
    lit("rst_inst", inst, m_inst, 0);
    lit("rst_fault", 32'(fetch_fault), 32'(m_fault), 0);

    // First fetch, zero-wait memory.
    rst_n = 1; req_ready = 1; ovr_en = 1; ovr_data = 32'h00100093;
    tick();
    lit("first_req_valid", 32'(req_valid), 32'(e_req()), 1);
    tick(); tick();
    lit("first_inst_valid", 32'(inst_valid), 32'(m_hold), 1);
    lit("first_inst", inst, m_inst, 32'h00100093);
    lit("first_inst_pc", inst_pc, m_pc, 32'h8000_0000);

    // Decoder stall: instruction held, no new request.
    for (int i = 0; i < 5; i++) begin
      tick();
      lit("stall_inst_valid", 32'(inst_valid), 32'(m_hold), 1);
      lit("stall_inst", inst, m_inst, 32'h00100093);
      lit("stall_req_valid", 32'(req_valid), 32'(e_req()), 0);
    end
    inst_ready = 1;
    tick();
    inst_ready = 0;
    lit("next_req_valid", 32'(req_valid), 32'(e_req()), 1);
    lit("next_req_addr", req_addr, m_pc, 32'h8000_0004);

    // Redirect while waiting; late response must be dropped.
    ovr_data = 32'hDEADBEEF; mem_dly = 2;
    tick();
    redirect_valid = 1; redirect_pc = 32'h8000_0100;
    tick(); tick();
    lit("stale_rsp_seen", 32'(rsp_valid), 32'(rsp_valid), 1);
    tick();
    lit("stale_inst_valid", 32'(inst_valid), 32'(m_hold), 0);
    lit("redir_req_addr", req_addr, m_pc, 32'h8000_0100);
    ovr_en = 0; mem_dly = 0;
    tick(); tick();
    lit("redir_inst_pc", inst_pc, m_pc, 32'h8000_0100);

    // Redirect same cycle as consume wins over pc+4.
    inst_ready = 1; redirect_valid = 1; redirect_pc = 32'h8000_0200;
    tick();
    inst_ready = 0;
    lit("hold_redir_addr", req_addr, m_pc, 32'h8000_0200);

    // PC wrap.
    req_ready = 0; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    lit("wrap_pre_addr", req_addr, m_pc, 32'hFFFF_FFFC);
    req_ready = 1;
    tick(); tick();
    lit("wrap_inst_pc", inst_pc, m_pc, 32'hFFFF_FFFC);
    inst_ready = 1;
    tick();
    inst_ready = 0; req_ready = 0;
    lit("wrap_addr", req_addr, m_pc, 32'h0000_0000);

    // Misaligned redirect.
    redirect_valid = 1; redirect_pc = 32'h8000_0002;
    tick();
`ifdef IFU_MISALIGN_CHECK_EN
    lit("mis_fault", 32'(fetch_fault), 32'(m_fault), 1);
    lit("mis_req_valid", 32'(req_valid), 32'(e_req()), 0);
    req_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    lit("mis_sticky_fault", 32'(fetch_fault), 32'(m_fault), 1);
    lit("mis_sticky_req", 32'(req_valid), 32'(e_req()), 0);
`else
    lit("mis_addr", req_addr, m_pc, 32'h8000_0000);
    lit("mis_fault", 32'(fetch_fault), 32'(m_fault), 0);
`endif

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      req_ready  = ($urandom % 4) != 0;
      inst_ready = ($urandom % 3) != 0;
      mem_dly    = $urandom % 3;
      if (($urandom % 10) == 0) begin
        redirect_valid = 1;
        redirect_pc = (($urandom % 4) == 0) ? 32'hFFFF_FFF0 + 32'(($urandom % 4) * 4)
                                            : 32'h8000_0000 + 32'(($urandom % 256) * 4);
        if (($urandom % 8) == 0) redirect_pc = redirect_pc + 32'(1 + $urandom % 3);
      end
      if (!rsp_valid && pend < 0 && ($urandom % 12) == 0) begin
        rsp_valid = 1; rsp_data = $urandom;
      end
      tick();
      if (($urandom % 300) == 0 || (m_fault && ($urandom % 20) == 0)) do_reset();
    end

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
